// File: rtl/mem_access_stage_if.sv
// Data-memory request/response bus between the MEM stage and the data memory.
// master: the MEM stage, which issues requests.
// slave:  the data memory, which completes them with a one-cycle ready pulse.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_wdata,
        input  dmem_ready,
        input  dmem_rdata
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_wdata,
        output dmem_ready,
        output dmem_rdata
    );
endinterface

// File: rtl/mem_access_stage.sv
// Memory-access stage of the 5-stage MIPS pipeline (EX/MEM -> MEM/WB).
// Non-memory instructions pass straight through with no added latency.
// A load or store is latched, issued on the dmem bus, and the upstream
// pipeline is stalled until the memory answers or the watchdog gives up.
//
// Optional build macro: MEM_ALIGN_CHECK_EN
//   defined     - misaligned accesses are dropped (no request, no stall,
//                 bubble to MEM/WB) and the sticky align_error is raised.
//   not defined - no alignment check, address used as-is, align_error = 0.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access outstanding; outputs follow EX/MEM combinationally
// BUSY  | request held on dmem bus, pipeline stalled, watchdog running
// DONE  | access finished; latched result presented, pipeline released
module mem_access_stage #(
    parameter int unsigned WAIT_LIMIT = 16,
    parameter int unsigned CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] ALU_result,
    input  logic [31:0] write_data,
    input  logic [1:0]  control_signal_WB,
    input  logic [4:0]  reg_dst_EX_MEM,

    mem_access_stage_if.master dmem,

    output logic        stall,
    output logic [31:0] result_out,
    output logic [31:0] MEM_read_data,
    output logic [1:0]  control_signal_WB_out,
    output logic [4:0]  reg_dst_out,
    output logic        bus_error,
    output logic        align_error
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [31:0] ABORT_DATA = 32'hDEAD_BEEF;

    state_t            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [31:0]       alu_q;
    logic [31:0]       wdata_q;
    logic              we_q;
    logic [1:0]        ctl_q;
    logic [4:0]        rd_q;
    logic [31:0]       rdata_q;
    logic              abort_q;
    logic              bus_err_q;

    logic              access;
    logic              misaligned;
    logic              issue;
    logic              limit_hit;

    assign access = mem_read | mem_write;

`ifdef MEM_ALIGN_CHECK_EN
    logic align_err_q;
    assign misaligned  = access & (ALU_result[1:0] != 2'b00);
    assign align_error = align_err_q;
`else
    assign misaligned  = 1'b0;
    assign align_error = 1'b0;
`endif

    assign issue     = access & ~misaligned;
    assign cnt_d     = cnt_q + CNT_W'(1);
    assign limit_hit = (cnt_d == CNT_W'(WAIT_LIMIT));

    // Access sequencer: latches the EX/MEM fields, waits for ready or the watchdog.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            alu_q     <= '0;
            wdata_q   <= '0;
            we_q      <= 1'b0;
            ctl_q     <= 2'b00;
            rd_q      <= '0;
            rdata_q   <= '0;
            abort_q   <= 1'b0;
            bus_err_q <= 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
            align_err_q <= 1'b0;
`endif
        end else begin
            case (state_q)
                IDLE: begin
                    if (issue) begin
                        alu_q   <= ALU_result;
                        wdata_q <= write_data;
                        // both read and write set behaves as a store
                        we_q    <= mem_write;
                        ctl_q   <= control_signal_WB;
                        rd_q    <= reg_dst_EX_MEM;
                        cnt_q   <= '0;
                        abort_q <= 1'b0;
                        state_q <= BUSY;
                    end
`ifdef MEM_ALIGN_CHECK_EN
                    else if (misaligned) begin
                        align_err_q <= 1'b1;
                    end
`endif
                end
                BUSY: begin
                    // a ready arriving on the limit cycle still counts as success
                    if (dmem.dmem_ready) begin
                        if (!we_q) begin
                            rdata_q <= dmem.dmem_rdata;
                        end
                        state_q <= DONE;
                    end else if (limit_hit) begin
                        bus_err_q <= 1'b1;
                        rdata_q   <= ABORT_DATA;
                        abort_q   <= 1'b1;
                        cnt_q     <= cnt_d;
                        state_q   <= DONE;
                    end else begin
                        cnt_q <= cnt_d;
                    end
                end
                DONE: begin
                    // EX/MEM advances on this edge, so the access is never re-issued
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign dmem.dmem_req   = (state_q == BUSY);
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = alu_q;
    assign dmem.dmem_wdata = wdata_q;
    assign bus_error       = bus_err_q;

    // MEM/WB-facing outputs: live passthrough in IDLE, latched values otherwise.
    always_comb begin
        stall                 = 1'b0;
        result_out            = ALU_result;
        MEM_read_data         = rdata_q;
        control_signal_WB_out = control_signal_WB;
        reg_dst_out           = reg_dst_EX_MEM;
        case (state_q)
            IDLE: begin
                if (access) begin
                    control_signal_WB_out = 2'b00;
                    stall                 = issue;
                end
            end
            BUSY: begin
                stall                 = 1'b1;
                result_out            = alu_q;
                control_signal_WB_out = 2'b00;
                reg_dst_out           = rd_q;
            end
            DONE: begin
                result_out            = alu_q;
                control_signal_WB_out = abort_q ? 2'b00 : ctl_q;
                reg_dst_out           = rd_q;
            end
            default: begin
                stall = 1'b0;
            end
        endcase
    end

endmodule
